// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter predictor with tagged BTB for the IF stage
// Ports: if_pc -> pred_taken/pred_target (combinational lookup);
//        upd_en/upd_pc/upd_taken/upd_target/upd_pred_* -> table training plus mispredict/redirect_pc;
//        reset is asynchronous, active-high.
// Define BP_STATS_EN to add the stat_branches/stat_mispredicts counter outputs.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;
  logic [1:0]       cntMem    [ENTRIES];
  logic             validMem  [ENTRIES];
  logic [TAG_W-1:0] tagMem    [ENTRIES];
  logic [31:0]      targetMem [ENTRIES];
  logic [IDX_BITS-1:0] ifIdx, updIdx;
  logic [TAG_W-1:0]    ifTag, updTag;
  logic [1:0]          updCnt;
  assign ifIdx  = if_pc[IDX_BITS+1:2];
  assign ifTag  = if_pc[31:IDX_BITS+2];
  assign updIdx = upd_pc[IDX_BITS+1:2];
  assign updTag = upd_pc[31:IDX_BITS+2];
  assign updCnt = cntMem[updIdx];
  // Lookup reads the stored state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_taken  = cntMem[ifIdx][1] & validMem[ifIdx] & (tagMem[ifIdx] == ifTag);
    pred_target = pred_taken ? targetMem[ifIdx] : if_pc + 32'd4;
    mispredict  = upd_en & ((upd_taken != upd_pred_taken) |
                  (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end
  // Counter trains without a tag check; only taken outcomes (re)allocate the BTB entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cntMem[i]    <= 2'b01;
        validMem[i]  <= 1'b0;
        tagMem[i]    <= '0;
        targetMem[i] <= '0;
      end
    end else if (upd_en) begin
      cntMem[updIdx] <= upd_taken ? ((updCnt == 2'd3) ? 2'd3 : updCnt + 2'd1)
                                  : ((updCnt == 2'd0) ? 2'd0 : updCnt - 2'd1);
      if (upd_taken) begin
        validMem[updIdx]  <= 1'b1;
        tagMem[updIdx]    <= updTag;
        targetMem[updIdx] <= upd_target;
      end
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_branches    <= stat_branches + {31'd0, upd_en};
      stat_mispredicts <= stat_mispredicts + {31'd0, mispredict};
    end
  end
`endif
endmodule
